ks_note_seq: RTL
================

# ks_note_seq

Note scheduler that sequences one `ks_string` voice from a queue of note events. Note events (period, duration, drum/string select) arrive over a valid/ready handshake into a small FIFO. Notes are issued one at a time, aligned to the audio sample strobe. For each note the block drives the string's `period_i`, `drum_string_ni`, `pluck_i` and `freeze_i` inputs. It sits between the host/pattern logic and the string datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of period and of the string sample path.
- `MAX_LENGTH`, 8, string delay-line length; upper clamp for period.
- `DUR_WIDTH`, 16, width of the note duration field, in sample ticks.
- `FIFO_DEPTH`, 4, note queue entries; power of two, at least 2.
- `PLUCK_LEN`, 2, sample ticks during which `pluck_o` is held high; at least 1.

Ports:
- `clk_i`, in, 1, system clock.
- `rst_n`, in, 1, reset; synchronous, active-low. Clock is `clk_i`.
- `sample_tick_i`, in, 1, one-cycle strobe at the audio sample rate.
- `note_valid_i`, in, 1, note event valid.
- `note_ready_o`, out, 1, queue can accept a note.
- `note_period_i`, in, `DATA_WIDTH`, string period in samples; 0 means a rest.
- `note_dur_i`, in, `DUR_WIDTH`, ring time in sample ticks after the pluck.
- `note_drum_i`, in, 1, 1 selects drum mode, 0 selects string mode.
- `pluck_o`, out, 1, drives `pluck_i` of the string.
- `period_o`, out, `DATA_WIDTH`, drives `period_i` of the string.
- `drum_string_no`, out, 1, drives `drum_string_ni` of the string.
- `freeze_o`, out, 1, drives `freeze_i` of the string.
- `busy_o`, out, 1, a note or rest is in progress.
- `fifo_level_o`, out, `$clog2(FIFO_DEPTH)+1` bits, number of queued entries.

## Operation
- Queue behaviour:
  - Accepting a note: a note is pushed when `note_valid_i && note_ready_o`.
  - Ready: `note_ready_o = (level != FIFO_DEPTH)`, combinational from the level register.
  - No bypass: a note pushed in a given cycle can be popped no earlier than the next cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states are IDLE, PLUCK and RING.
- IDLE:
  - On `sample_tick_i` with the FIFO non-empty: pop the head entry and latch its fields.
  - Period 0: go to RING; `period_o` and `drum_string_no` keep their previous values.
  - Nonzero period: go to PLUCK. `period_o` is loaded with the period clamped to the range [2, `MAX_LENGTH`]. `drum_string_no` is loaded with the drum bit.
  - Tick counter: loaded with `PLUCK_LEN` (PLUCK) or `max(dur,1)` (RING).
- PLUCK:
  - `pluck_o`=1.
  - Counter decrements on each tick.
  - On the tick where the counter is 1: go to RING with counter = `max(dur,1)`; `pluck_o` returns to 0.
- RING:
  - `pluck_o`=0; the counter decrements on each tick.
  - On the tick where the counter is 1, the note ends.
  - If the FIFO is non-empty, pop on that same tick and take the IDLE pop path immediately (back-to-back notes). Otherwise go to IDLE.
- Every pluck has at least one tick of `pluck_o`=0 before it. This guarantees a rising edge for the string's edge detector.
- Total note length is `PLUCK_LEN + max(dur,1)` ticks; a rest lasts `max(dur,1)` ticks.
- `busy_o` = (state != IDLE).
- Reset mid-note aborts immediately: the FIFO is emptied and all outputs take their reset values.
- The period clamp is combinational on the popped value; arithmetic is unsigned.

## Timing
- Reset values:
  - `pluck_o`=0, `period_o`=`MAX_LENGTH`, `drum_string_no`=0.
  - `freeze_o`=1 if `KS_SEQ_AUTO_FREEZE_EN` is defined, else 0.
  - `busy_o`=0, `fifo_level_o`=0, `note_ready_o`=1, state IDLE.
- All outputs except `note_ready_o` are registered. They update in the cycle after the qualifying `sample_tick_i`.
- Latency:
  - Push in cycle n: `fifo_level_o` increments at n+1.
  - The earliest pop is on the first tick at n+1 or later.
  - `pluck_o` rises one clock after that tick.
- `pluck_o` stays high for exactly `PLUCK_LEN` ticks. That is at least 2 clocks whenever ticks are at least 2 clocks apart, which the system guarantees.
- `period_o` and `drum_string_no` change only in the cycle after a pop. They never change in the middle of a note.

## Configuration
- Macro `KS_SEQ_AUTO_FREEZE_EN`.
  - Defined: `freeze_o`=1 in IDLE and 0 in PLUCK and RING. It updates with the state register, so the string holds its contents between notes.
  - Undefined: `freeze_o` is tied to 0 and the string free-runs and decays between notes.

## Test plan
- Single note: push period=5, dur=3, drum=0, with a tick every 4 clocks → `pluck_o` high for 2 ticks, `period_o`=5, `busy_o` high for 5 ticks, then IDLE.
- Queue full: push 4 notes with no ticks → `fifo_level_o`=4, `note_ready_o`=0. A 5th note is held off and accepted the cycle after the first pop.
- Back-to-back: queue two notes with periods 3 and 7 → the second pluck starts on the tick that ends the first note; `pluck_o` is low ≥1 tick between them; `busy_o` never drops.
- Rest and clamp:
  - period=0, dur=4 → no pluck, `period_o` unchanged, `busy_o` for 4 ticks.
  - period=200 → `period_o`=8.
  - period=1 → `period_o`=2.
- dur=0 → ring lasts 1 tick (total 3 ticks with `PLUCK_LEN`=2).
- Reset mid-RING with 2 queued notes → next cycle all reset values, `fifo_level_o`=0; no pluck follows without a new push.

Source files
------------

// File: rtl/ks_note_seq.sv
// ks_note_seq: schedules one ks_string voice from a small queue of note events.
// Notes (period, duration, drum select) are queued through a valid/ready handshake
// and issued one at a time on sample ticks as a pluck phase followed by a ring phase.
// Optional build macro: KS_SEQ_AUTO_FREEZE_EN freezes the string while idle.
module ks_note_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LENGTH = 8,
    parameter int DUR_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PLUCK_LEN  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic                          sample_tick_i,
    input  logic                          note_valid_i,
    output logic                          note_ready_o,
    input  logic [DATA_WIDTH-1:0]         note_period_i,
    input  logic [DUR_WIDTH-1:0]          note_dur_i,
    input  logic                          note_drum_i,
    output logic                          pluck_o,
    output logic [DATA_WIDTH-1:0]         period_o,
    output logic                          drum_string_no,
    output logic                          freeze_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PL_W  = $clog2(PLUCK_LEN + 1);
    localparam int CNT_W = (DUR_WIDTH > PL_W) ? DUR_WIDTH : PL_W;
    localparam logic [DATA_WIDTH-1:0] PERIOD_MAX = DATA_WIDTH'(MAX_LENGTH);
    localparam logic [DATA_WIDTH-1:0] PERIOD_MIN = DATA_WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE,
        PLUCK,
        RING
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mem_period [FIFO_DEPTH];
    logic [DUR_WIDTH-1:0]   mem_dur    [FIFO_DEPTH];
    logic                   mem_drum   [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       ring_len;
    logic                   push;
    logic                   pop;
    logic                   note_end;
    logic [DATA_WIDTH-1:0]  head_period;
    logic [DATA_WIDTH-1:0]  head_period_clamped;
    logic [CNT_W-1:0]       head_ring_len;

    assign note_ready_o = (level != LVL_W'(FIFO_DEPTH));
    assign push         = note_valid_i && note_ready_o;
    assign note_end     = sample_tick_i && (state == RING) && (cnt == CNT_W'(1));
    // Level register excludes this cycle's push, so a new entry cannot be popped before next cycle.
    assign pop          = (level != '0) && ((sample_tick_i && (state == IDLE)) || note_end);

    assign fifo_level_o = level;
    assign busy_o       = (state != IDLE);

`ifdef KS_SEQ_AUTO_FREEZE_EN
    assign freeze_o = (state == IDLE);
`else
    assign freeze_o = 1'b0;
`endif

    // Decode the head entry: clamp the period and enforce a ring of at least one tick.
    always_comb begin
        head_period         = mem_period[rd_ptr];
        head_period_clamped = head_period;
        if (head_period < PERIOD_MIN) begin
            head_period_clamped = PERIOD_MIN;
        end else if (head_period > PERIOD_MAX) begin
            head_period_clamped = PERIOD_MAX;
        end
        head_ring_len = (mem_dur[rd_ptr] == '0) ? CNT_W'(1) : CNT_W'(mem_dur[rd_ptr]);
    end

    // Queue storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_period[wr_ptr] <= note_period_i;
            mem_dur[wr_ptr]    <= note_dur_i;
            mem_drum[wr_ptr]   <= note_drum_i;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Note sequencer: issues pluck and ring phases and the string controls.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            ring_len       <= '0;
            pluck_o        <= 1'b0;
            period_o       <= PERIOD_MAX;
            drum_string_no <= 1'b0;
        end else if (pop) begin
            // Shared by the idle start and the back-to-back handoff at the end of a ring.
            if (head_period == '0) begin
                state   <= RING;
                cnt     <= head_ring_len;
                pluck_o <= 1'b0;
            end else begin
                state          <= PLUCK;
                cnt            <= CNT_W'(PLUCK_LEN);
                ring_len       <= head_ring_len;
                pluck_o        <= 1'b1;
                period_o       <= head_period_clamped;
                drum_string_no <= mem_drum[rd_ptr];
            end
        end else if (sample_tick_i) begin
            case (state)
                PLUCK: begin
                    if (cnt == CNT_W'(1)) begin
                        state   <= RING;
                        cnt     <= ring_len;
                        pluck_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RING: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
